random_bank: RTL

Parametrised bank of CHANNELS independent pseudo-random number generators, each drawing a WIDTH-bit value inside a runtime-programmable range [rangeMin, rangeMax] on a trigger edge. It is the successor of the fixed 4-bit generator array used by game logic (spawn positions, enemy timing). It adds:

- per-channel runtime ranges
- configurable width
- a busy/valid handshake
- a bounded-latency rejection sampler, so results are uniform inside the range rather than clipped

---
 rtl/random_pkg.sv | 20 ++
 rtl/random_bank_lfsr16.sv | 23 ++
 rtl/random_bank.sv | 130 +++++++++++++
 3 files changed

// File: rtl/random_pkg.sv
// Shared types and helpers for the random_bank generator array.
// Seeds, LFSR polynomial and FSM encoding live here.
package random_pkg;

    localparam logic [15:0] LFSR_POLY = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        DONE
    } state_t;

    // A zero seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [15:0] seed_for(int i, logic [15:0] base);
        logic [15:0] s;
        s = base ^ 16'((i + 1) * 32'h1F35);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/random_bank_lfsr16.sv
// 16-bit Galois LFSR, free running from reset.
// Steps every clock regardless of what the consumer is doing.
module lfsr16
    import random_pkg::*;
#(
    parameter logic [15:0] SEED = 16'h0001
) (
    input  logic        clk,
    input  logic        resetN,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= SEED;
        end else if (state[0]) begin
            state <= (state >> 1) ^ LFSR_POLY;
        end else begin
            state <= state >> 1;
        end
    end

endmodule

// File: rtl/random_bank.sv
// Bank of LFSR-backed generators drawing uniform values inside
// per-channel ranges, using bounded rejection sampling.
module random_bank
    import random_pkg::*;
#(
    parameter int          CHANNELS  = 3,
    parameter int          WIDTH     = 4,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          MAX_TRIES = 8
) (
    input  logic                             clk,
    input  logic                             resetN,
    input  logic                             trigger,
    input  logic [CHANNELS-1:0][WIDTH-1:0]   rangeMin,
    input  logic [CHANNELS-1:0][WIDTH-1:0]   rangeMax,
    output logic [CHANNELS-1:0][WIDTH-1:0]   randomNumbers,
    output logic                             valid,
    output logic                             busy,
    output logic [CHANNELS-1:0]              rangeErr
);

    localparam int             TW   = $clog2(MAX_TRIES + 1);
    localparam logic [TW-1:0]  LAST = TW'(MAX_TRIES - 1);

    state_t                           state;
    logic                             trigger_d;
    logic [TW-1:0]                    tries;
    logic [CHANNELS-1:0]              acc;
    logic [CHANNELS-1:0][WIDTH-1:0]   lo;
    logic [CHANNELS-1:0][WIDTH-1:0]   hi;
    logic [CHANNELS-1:0][WIDTH-1:0]   res;

    logic [15:0]                      lfsr [CHANNELS];
    logic [CHANNELS-1:0][WIDTH-1:0]   cand;
    logic [CHANNELS-1:0][WIDTH-1:0]   pick;
    logic [CHANNELS-1:0]              hit;
    logic [CHANNELS-1:0]              take;
    logic                             last_try;
    logic                             rise;
    logic                             lfsr_unused;

    for (genvar g = 0; g < CHANNELS; g++) begin : gen_ch
        lfsr16 #(
            .SEED (seed_for(g, SEED))
        ) u_lfsr (
            .clk    (clk),
            .resetN (resetN),
            .state  (lfsr[g])
        );
    end

    assign rise     = trigger & ~trigger_d;
    assign last_try = (tries == LAST);

    // A channel accepts on a hit, on a degenerate range, or on the
    // final try, where it falls back to its lower bound.
    always_comb begin
        cand        = '0;
        pick        = '0;
        hit         = '0;
        take        = '0;
        lfsr_unused = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            cand[i]     = lfsr[i][WIDTH-1:0];
            hit[i]      = (cand[i] >= lo[i]) && (cand[i] <= hi[i]);
            pick[i]     = hit[i] ? cand[i] : lo[i];
            take[i]     = ~acc[i] & (hit[i] | last_try | (lo[i] == hi[i]));
            lfsr_unused = lfsr_unused ^ (^lfsr[i]);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= IDLE;
            trigger_d     <= 1'b0;
            tries         <= '0;
            acc           <= '0;
            lo            <= '0;
            hi            <= '0;
            res           <= '0;
            randomNumbers <= '0;
            valid         <= 1'b0;
            busy          <= 1'b0;
            rangeErr      <= '0;
        end else begin
            trigger_d <= trigger;
            valid     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        lo    <= rangeMin;
                        hi    <= rangeMax;
                        tries <= '0;
                        busy  <= 1'b1;
                        state <= DRAW;
                        for (int i = 0; i < CHANNELS; i++) begin
                            rangeErr[i] <= rangeMin[i] > rangeMax[i];
                            acc[i]      <= rangeMin[i] > rangeMax[i];
                            res[i]      <= rangeMin[i];
                        end
                    end
                end
                DRAW: begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (take[i]) begin
                            res[i] <= pick[i];
                        end
                    end
                    acc <= acc | take;
                    if (&(acc | take)) begin
                        state <= DONE;
                    end else begin
                        tries <= tries + 1'b1;
                    end
                end
                DONE: begin
                    randomNumbers <= res;
                    valid         <= 1'b1;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
